note_input: RTL and testbench
=============================

# note_input

Front-panel input block for the synthesiser: five pushbuttons are synchronised and debounced, and the resulting presses step a note/octave/accident state. It produces the same `note`, `octave` and `accident` signals that the 7-segment display driver and tone generator consume, so it is the producer end of that interface. It sits between the board buttons and the display/tone path, and adds a one-cycle `changed` strobe so downstream logic can retrigger.

## Interface
- `DEBOUNCE_CYCLES`, default 262144: consecutive stable cycles required before a button level is accepted (about 2.6 ms at 100 MHz); legal range is 2 or more.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `btn_up`  in  1  raw button, asynchronous; steps the note up.
- `btn_down`  in  1  raw button; steps the note down.
- `btn_right`  in  1  raw button; octave up.
- `btn_left`  in  1  raw button; octave down.
- `btn_center`  in  1  raw button; toggles the accident (sharp).
- `note`  out  3  0=C, 1=D, 2=E, 3=F, 4=G, 5=A, 6=B; the value 7 is never driven.
- `octave`  out  2  0..3.
- `accident`  out  1  1 = sharp.
- `changed`  out  1  one-cycle pulse, asserted in the same cycle any output takes a new value.

## Operation
- Reset values, applied asynchronously: `note`=0, `octave`=1, `accident`=0, `changed`=0. All synchroniser flops, debounce counters and debounced levels clear to 0.
- Synchronisation: each button passes through a 2-flop synchroniser.
- Debounce, per button:
  - A counter runs while the synchronised level differs from the debounced level.
  - The debounced level takes the new value when the counter reaches `DEBOUNCE_CYCLES-1` and the level still differs.
  - Any cycle where the synchronised level equals the debounced level clears the counter to 0.
- A press is a 0→1 transition of a debounced level. Releases are ignored, and a held button generates exactly one press.
- Up: `note` increments.
  - B wraps to C. The wrap also carries `octave`+1 if `octave`<3.
  - At B with octave 3, up is ignored: no change and no `changed`.
- Down: `note` decrements.
  - C wraps to B. The wrap also borrows `octave`-1 if `octave`>0.
  - At C with octave 0, down is ignored.
- Right/left: `octave` saturates at 3 and at 0. A press at the limit produces no change and no `changed`.
- Center: toggles `accident`. The toggle is ignored when `note` is E or B, because those notes have no sharp.
- Any note step whose result is E or B forces `accident`=0 in the same update.
- Simultaneous presses in one cycle: only the highest-priority press is acted on, and the others are discarded. Priority order is up, down, right, left, center.
- `changed` asserts only if at least one of `note`, `octave` or `accident` actually differs from its previous value.

## Timing
- Latency: a button level is first sampled high at clock edge k and held stable. The debounced level rises at edge k+`DEBOUNCE_CYCLES`+1. The outputs and `changed` update at edge k+`DEBOUNCE_CYCLES`+2.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no press.
- `changed` is high for exactly one cycle and low otherwise; there is no backpressure.
- Reset asserted mid-debounce or mid-update wins immediately. After release, a button that is still held must re-qualify for a full `DEBOUNCE_CYCLES` before it produces a press.
- The outputs are registered, with no combinational path from the buttons.

## Structure
- Shared package `synth_pkg` holds:
  - note encoding constants `NOTE_C`..`NOTE_B` (0..6);
  - `OCTAVE_MIN`=0, `OCTAVE_MAX`=3, `OCTAVE_RESET`=1;
  - the button index order used for priority.
- Sub-module `button_debounce` (parameter `DEBOUNCE_CYCLES`, ports `clk`, `rst`, `btn_raw`, `level`, `press`) is instantiated five times. The top level holds only the priority selection and the note/octave/accident state register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4.
- Reset then idle: outputs are C, octave 1, accident 0, and `changed` stays 0 for 100 cycles.
- Clean press of up, held for 20 cycles: `note` goes 0→1 at edge k+6 with one `changed` pulse, and there is no second pulse while the button is held or on release.
- Bounce: toggle up at 1-, 2- and 3-cycle intervals, then hold high. Expect a single press, 6 edges after the final rising sample.
- Wrap and saturation:
  - From B, octave 1, press up: expect C, octave 2.
  - From C, octave 0, press down: expect no change and no `changed`.
  - Press right 4 times from octave 1: expect 3, with exactly 2 `changed` pulses.
- Accident rules:
  - At C, press center: `accident`=1.
  - Press up to reach D: `accident` stays 1.
  - Press up to reach E: `accident` clears to 0.
  - At E, press center: ignored.
- Simultaneous up and center pressed in the same cycle: only the note steps. Then assert `rst` mid-debounce of a held button: expect immediate reset values and a fresh 4-cycle qualification after release.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared synthesiser definitions: note encoding, octave limits, button
// priority order and the note/octave/accident state payload.
package synth_pkg;

  localparam int unsigned NOTE_W   = 3;
  localparam int unsigned OCT_W    = 2;
  localparam int unsigned NUM_BTNS = 5;

  localparam logic [NOTE_W-1:0] NOTE_C = 3'd0;
  localparam logic [NOTE_W-1:0] NOTE_D = 3'd1;
  localparam logic [NOTE_W-1:0] NOTE_E = 3'd2;
  localparam logic [NOTE_W-1:0] NOTE_F = 3'd3;
  localparam logic [NOTE_W-1:0] NOTE_G = 3'd4;
  localparam logic [NOTE_W-1:0] NOTE_A = 3'd5;
  localparam logic [NOTE_W-1:0] NOTE_B = 3'd6;

  localparam logic [OCT_W-1:0] OCTAVE_MIN   = 2'd0;
  localparam logic [OCT_W-1:0] OCTAVE_MAX   = 2'd3;
  localparam logic [OCT_W-1:0] OCTAVE_RESET = 2'd1;

  // Button index; lower value wins when presses coincide.
  typedef enum logic [2:0] {
    BTN_UP     = 3'd0,
    BTN_DOWN   = 3'd1,
    BTN_RIGHT  = 3'd2,
    BTN_LEFT   = 3'd3,
    BTN_CENTER = 3'd4
  } btn_idx_e;

  typedef struct packed {
    logic [NOTE_W-1:0] note;
    logic [OCT_W-1:0]  octave;
    logic              accident;
  } note_state_t;

  localparam note_state_t STATE_RESET = '{note: NOTE_C, octave: OCTAVE_RESET, accident: 1'b0};

  // E and B have no sharp.
  function automatic logic has_sharp(input logic [NOTE_W-1:0] n);
    return !((n == NOTE_E) || (n == NOTE_B));
  endfunction

endpackage

// File: rtl/note_input_if.sv
// Front-panel bus: raw buttons in, note/octave/accident/changed out.
//   master : the note_input block (consumes buttons, drives note state)
//   slave  : board/downstream side (drives buttons, consumes note state)
interface note_input_if;
  import synth_pkg::*;

  logic              btn_up;
  logic              btn_down;
  logic              btn_right;
  logic              btn_left;
  logic              btn_center;
  logic [NOTE_W-1:0] note;
  logic [OCT_W-1:0]  octave;
  logic              accident;
  logic              changed;

  modport master (
    input  btn_up, btn_down, btn_right, btn_left, btn_center,
    output note, octave, accident, changed
  );

  modport slave (
    output btn_up, btn_down, btn_right, btn_left, btn_center,
    input  note, octave, accident, changed
  );

endinterface

// File: rtl/button_debounce.sv
// Two-flop synchroniser plus stable-count debouncer for one raw button.
// Ports:
//   clk, rst  : clock, async active-high reset
//   btn_raw   : asynchronous raw button level
//   level     : debounced level
//   press     : one-cycle pulse, registered, the cycle after level rises
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 262144
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_press;
  logic             w_differs;
  logic             w_accept;

  assign w_differs = r_sync[1] ^ r_level;
  assign w_accept  = w_differs && (r_cnt == CNT_LAST);

  // Synchroniser, stability counter and accepted level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn_raw};
      r_press <= w_accept & r_sync[1];
      if (w_accept) begin
        r_level <= r_sync[1];
        r_cnt   <= '0;
      end else if (w_differs) begin
        r_cnt   <= r_cnt + CNT_W'(1);
      end else begin
        r_cnt   <= '0;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/note_input.sv
// Front-panel input: debounces five buttons and steps note/octave/accident.
// Ports:
//   clk, rst : clock, async active-high reset
//   bus      : note_input_if.master (buttons in; note, octave, accident,
//              changed out, all registered)
module note_input
  import synth_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 262144
) (
  input  logic         clk,
  input  logic         rst,
  note_input_if.master bus
);

  logic [NUM_BTNS-1:0] w_btn_raw;
  logic [NUM_BTNS-1:0] w_press;
  logic [NUM_BTNS-1:0] w_unused_level;
  note_state_t         r_state;
  note_state_t         w_next;
  logic                r_changed;
  logic                w_changed;

  assign w_btn_raw[BTN_UP]     = bus.btn_up;
  assign w_btn_raw[BTN_DOWN]   = bus.btn_down;
  assign w_btn_raw[BTN_RIGHT]  = bus.btn_right;
  assign w_btn_raw[BTN_LEFT]   = bus.btn_left;
  assign w_btn_raw[BTN_CENTER] = bus.btn_center;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_db
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .rst    (rst),
      .btn_raw(w_btn_raw[g]),
      .level  (w_unused_level[g]),
      .press  (w_press[g])
    );
  end

  // Highest-priority press selects the single update for this cycle.
  always_comb begin
    w_next = r_state;
    if (w_press[BTN_UP]) begin
      if (r_state.note == NOTE_B) begin
        if (r_state.octave != OCTAVE_MAX) begin
          w_next.note   = NOTE_C;
          w_next.octave = r_state.octave + OCT_W'(1);
        end
      end else begin
        w_next.note = r_state.note + NOTE_W'(1);
      end
    end else if (w_press[BTN_DOWN]) begin
      if (r_state.note == NOTE_C) begin
        if (r_state.octave != OCTAVE_MIN) begin
          w_next.note   = NOTE_B;
          w_next.octave = r_state.octave - OCT_W'(1);
        end
      end else begin
        w_next.note = r_state.note - NOTE_W'(1);
      end
    end else if (w_press[BTN_RIGHT]) begin
      if (r_state.octave != OCTAVE_MAX) begin
        w_next.octave = r_state.octave + OCT_W'(1);
      end
    end else if (w_press[BTN_LEFT]) begin
      if (r_state.octave != OCTAVE_MIN) begin
        w_next.octave = r_state.octave - OCT_W'(1);
      end
    end else if (w_press[BTN_CENTER]) begin
      if (has_sharp(r_state.note)) begin
        w_next.accident = ~r_state.accident;
      end
    end
    // Landing on E or B drops any sharp in the same update.
    if (!has_sharp(w_next.note)) begin
      w_next.accident = 1'b0;
    end
  end

  assign w_changed = (w_next != r_state);

  // Note state and change strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= STATE_RESET;
      r_changed <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_changed <= w_changed;
    end
  end

  assign bus.note     = r_state.note;
  assign bus.octave   = r_state.octave;
  assign bus.accident = r_state.accident;
  assign bus.changed  = r_changed;

endmodule

// File: tb/tb_note_input.sv
// Self-checking bench for note_input with DEBOUNCE_CYCLES=4. A reference
// model tracks pitch as octave*7+note and each button as a run of samples.
module tb_note_input;

  localparam int D = 4;

  logic       clk;
  logic       rst;
  logic [4:0] btn;   // 0 up, 1 down, 2 right, 3 left, 4 center

  note_input_if u_if ();

  assign u_if.btn_up     = btn[0];
  assign u_if.btn_down   = btn[1];
  assign u_if.btn_right  = btn[2];
  assign u_if.btn_left   = btn[3];
  assign u_if.btn_center = btn[4];

  note_input #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk),
    .rst(rst),
    .bus(u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int pulses = 0;
  int last_pulse = -1;
  int base;

  // Reference model state.
  bit m_lvl [5];
  int m_run [5];
  int m_due [5];
  int m_pitch;
  bit m_acc;
  bit m_chg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < 5; b++) begin
      m_lvl[b] = 1'b0;
      m_run[b] = 0;
      m_due[b] = -1;
    end
    m_pitch = 7;
    m_acc   = 1'b0;
    m_chg   = 1'b0;
  endtask

  task automatic model_step();
    int sel;
    int prev_p;
    bit prev_a;
    sel = -1;
    for (int b = 0; b < 5; b++) begin
      if (m_due[b] == cyc) begin
        if (sel < 0) sel = b;
        m_due[b] = -1;
      end
    end
    // D consecutive differing samples accept a level; a rise acts 3 edges later.
    for (int b = 0; b < 5; b++) begin
      if (btn[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == D) begin
          m_lvl[b] = btn[b];
          m_run[b] = 0;
          if (btn[b]) m_due[b] = cyc + 3;
        end
      end else begin
        m_run[b] = 0;
      end
    end
    prev_p = m_pitch;
    prev_a = m_acc;
    case (sel)
      0: if (m_pitch < 27) m_pitch++;
      1: if (m_pitch > 0) m_pitch--;
      2: if (m_pitch / 7 < 3) m_pitch += 7;
      3: if (m_pitch / 7 > 0) m_pitch -= 7;
      4: if ((m_pitch % 7 != 2) && (m_pitch % 7 != 6)) m_acc = ~m_acc;
      default: ;
    endcase
    if ((m_pitch % 7 == 2) || (m_pitch % 7 == 6)) m_acc = 1'b0;
    m_chg = (m_pitch != prev_p) || (m_acc != prev_a);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_step();
    #1;
    if (u_if.changed) begin
      pulses++;
      last_pulse = cyc;
    end
    chk("note",     32'(u_if.note),     32'(m_pitch % 7));
    chk("octave",   32'(u_if.octave),   32'(m_pitch / 7));
    chk("accident", 32'(u_if.accident), 32'(m_acc));
    chk("changed",  32'(u_if.changed),  32'(m_chg));
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    repeat (8) tick();
    btn[b] = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    rst = 1'b1;
    btn = 5'b0;
    model_reset();
    repeat (3) tick();
    chk("rst_note", 32'(u_if.note), 0);
    chk("rst_oct",  32'(u_if.octave), 1);
    chk("rst_acc",  32'(u_if.accident), 0);
    chk("rst_chg",  32'(u_if.changed), 0);
    rst = 1'b0;

    // Idle: no strobes.
    pulses = 0;
    repeat (100) tick();
    chk("idle_pulses", pulses, 0);

    // Clean up press held 20 cycles.
    pulses = 0;
    base = cyc;
    btn[0] = 1'b1;
    repeat (20) tick();
    btn[0] = 1'b0;
    repeat (10) tick();
    chk("clean_pulses", pulses, 1);
    chk("clean_edge", last_pulse, base + 7);
    chk("clean_note", 32'(u_if.note), 1);

    // Bounce: highs of 1, 2, 3 cycles, then a steady hold.
    pulses = 0;
    btn[0] = 1'b1; tick();
    btn[0] = 1'b0; tick();
    btn[0] = 1'b1; repeat (2) tick();
    btn[0] = 1'b0; repeat (2) tick();
    btn[0] = 1'b1; repeat (3) tick();
    btn[0] = 1'b0; repeat (3) tick();
    base = cyc;
    btn[0] = 1'b1;
    repeat (20) tick();
    btn[0] = 1'b0;
    repeat (10) tick();
    chk("bounce_pulses", pulses, 1);
    chk("bounce_edge", last_pulse, base + 7);
    chk("bounce_note", 32'(u_if.note), 2);

    // E -> B in octave 1, then wrap to C octave 2.
    repeat (4) press(0);
    chk("at_b", 32'(u_if.note), 6);
    press(0);
    chk("wrap_note", 32'(u_if.note), 0);
    chk("wrap_oct",  32'(u_if.octave), 2);

    // Down at C octave 0 is ignored.
    repeat (2) press(3);
    pulses = 0;
    press(1);
    chk("floor_pulses", pulses, 0);
    chk("floor_note", 32'(u_if.note), 0);
    chk("floor_oct",  32'(u_if.octave), 0);

    // Right x4 from octave 1 saturates at 3.
    press(2);
    pulses = 0;
    repeat (4) press(2);
    chk("sat_oct", 32'(u_if.octave), 3);
    chk("sat_pulses", pulses, 2);

    // Accident rules.
    press(4);
    chk("c_sharp", 32'(u_if.accident), 1);
    press(0);
    chk("d_sharp", 32'(u_if.accident), 1);
    chk("d_note", 32'(u_if.note), 1);
    press(0);
    chk("e_clear", 32'(u_if.accident), 0);
    chk("e_note", 32'(u_if.note), 2);
    pulses = 0;
    press(4);
    chk("e_center_pulses", pulses, 0);
    chk("e_center_acc", 32'(u_if.accident), 0);

    // Up and center together: only the note steps.
    pulses = 0;
    btn[0] = 1'b1;
    btn[4] = 1'b1;
    repeat (8) tick();
    btn = 5'b0;
    repeat (8) tick();
    chk("simul_note", 32'(u_if.note), 3);
    chk("simul_acc", 32'(u_if.accident), 0);
    chk("simul_pulses", pulses, 1);

    // Reset mid-debounce of a held left button.
    btn[3] = 1'b1;
    repeat (2) tick();
    rst = 1'b1;
    #1;
    model_reset();
    chk("arst_note", 32'(u_if.note), 0);
    chk("arst_oct",  32'(u_if.octave), 1);
    chk("arst_acc",  32'(u_if.accident), 0);
    chk("arst_chg",  32'(u_if.changed), 0);
    repeat (3) tick();
    rst = 1'b0;
    pulses = 0;
    base = cyc;
    repeat (10) tick();
    chk("requal_edge", last_pulse, base + 7);
    chk("requal_oct", 32'(u_if.octave), 0);
    chk("requal_pulses", pulses, 1);
    btn = 5'b0;
    repeat (8) tick();

    // Randomised button activity against the model.
    repeat (80) begin
      btn = 5'($urandom);
      repeat ($urandom_range(1, 12)) tick();
    end
    btn = 5'b0;
    repeat (12) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
